vec_lane_sequencer: RTL and testbench
=====================================

Name: vec_lane_sequencer

Overview:
Parametrised successor to the fixed 4-lane ALU wrapper. It sequences one vector instruction across LANES element lanes, honouring vl, tail and (optionally) mask. Each beat it presents SEW-sized operands to the lanes, collects same-cycle lane results and assembles the destination register. It sits between the vector decode stage and LANES combinational vec_alu lane instances, with a start/busy/done handshake towards the core.

Parameters:
VLEN, 128, vector register width in bits (power of two, 64..1024)
LANES, 4, number of element lanes (power of two, 1..8)
ELEN, 64, maximum element width and lane datapath width
VLW, $clog2(VLEN/8)+1, width of vl (localparam)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
start  in  1  launch instruction; sampled only in IDLE
vsew  in  3  element width code; SEW = 8<<vsew, legal 0..3
op_type  in  3  one-hot: 001 VV, 010 VX, 100 VI
vl  in  VLW  active element count
vs1  in  VLEN  source 1 register
vs2  in  VLEN  source 2 register
vd_old  in  VLEN  prior destination contents (tail/mask-undisturbed source)
rs1  in  32  scalar operand for VX
imm5  in  5  immediate for VI
lane_ready  in  1  lanes accept current beat
lane_valid  out  LANES  per-lane element active this beat
lane_a  out  LANES*ELEN  vs2 elements, zero-extended from SEW
lane_b  out  LANES*ELEN  vs1 element / rs1 / imm5 per op_type
lane_res  in  LANES*ELEN  lane results; low SEW bits used
busy  out  1  instruction in progress
done  out  1  one-cycle completion pulse
vd  out  VLEN  assembled result, held until next start

Behaviour:
- Reset: state IDLE; busy=0, done=0, vd=0, lane_valid=0, lane_a=0, lane_b=0. Reset mid-RUN aborts with no partial writeback.
- FSM IDLE -> RUN -> FIN -> IDLE.
- IDLE: start=1 latches vsew, op_type, vs1, vs2, vd_old, rs1, imm5 and vl_eff = min(vl, VLEN>>(vsew+3)). It sets vd <= vd_old and base <= 0. Next state is FIN if vl_eff==0, else RUN.
- busy=1 in RUN and FIN.
- RUN: lane i carries element base+i. lane_valid[i] = (base+i < vl_eff).
- VX: lane_b = rs1 sign-extended or truncated to SEW. VI: lane_b = imm5 sign-extended to SEW. Bits above SEW in lane_a and lane_b are 0.
- A beat is accepted when lane_ready=1 in RUN. On acceptance, every valid lane writes lane_res[SEW-1:0] into vd at element base+i, and base += LANES.
- If base+LANES >= vl_eff on acceptance, next state is FIN. lane_ready=0 holds all lane outputs stable.
- FIN: done=1 for exactly one cycle, then IDLE.
- Latency with lane_ready=1: start in cycle 0, beats in cycles 1..B where B = ceil(vl_eff/LANES), done in cycle B+1.
- Tail elements (index >= vl_eff) keep their vd_old value.
- start while busy is ignored. start in the FIN cycle is ignored.
- vl greater than VLMAX is clamped silently. Illegal vsew > 3 is treated as vl_eff=0.
- Element index arithmetic is VLW+1 bits, so the final base+LANES overflows nothing.

Optional Feature:
VEC_SEQ_MASK_EN: adds input vm (1) and v0 (VLEN/8).
- Defined: element j is active only if vm==1 or v0[j]==1. Masked-off lanes have lane_valid=0 and keep their vd_old value (mask-undisturbed). v0 and vm are latched at start.
- Undefined: ports are absent and every body element is active.

Decomposition:
- Package vec_seq_pkg holds: op_type constants VV/VX/VI; state encoding IDLE/RUN/FIN; function vlmax(vsew); function sext_sew(value, vsew).
- Sub-module vec_elem_select (combinational): extracts a zero-extended SEW element at index idx from a VLEN register. It is instantiated 2*LANES times, and the same indexing logic drives the write-back.

Test Plan:
- SEW8, vl=16, VV add, vs1=vs2=0x0101...01, LANES=4, lane_ready=1 -> 4 beats, done in cycle 5, every byte of vd=0x02.
- SEW32, vl=3, vd_old=all 0xFF -> beat 1 lane_valid=0111; vd words 0..2 hold results, word 3=0xFFFFFFFF; done in cycle 2.
- vl=0 -> no lane_valid ever asserted, done in cycle 1, vd==vd_old.
- SEW16, vl=20 (VLMAX 8) -> clamped, 2 beats, all 8 elements written.
- lane_ready toggled 1,0,0,1 during SEW8 vl=8 -> lane_a/lane_b stable while stalled, done in cycle 5, same vd as the unstalled run.
- VX with rs1=0xFFFFFF80, SEW8 -> lane_b low byte 0x80 and upper bits 0. Reset asserted in beat 2 -> busy=0, vd=0 next cycle. Mask-enabled variant: v0=0x5555 -> odd elements keep their vd_old value.

Source files
------------

// File: rtl/vec_seq_pkg.sv
// vec_seq_pkg -- shared definitions for the vector lane sequencer.
//   * op_type one-hot codes (VV / VX / VI)
//   * sequencer state encoding (IDLE / RUN / FIN)
//   * vlmax()        : elements per register for a given vsew
//   * sew_mask()     : low-SEW-bit mask, 64 bits wide
//   * sext_sew()     : 32-bit signed scalar sign-extended, then cut to SEW
//   * elem_bit_off() : bit offset of element idx inside a register
package vec_seq_pkg;

  localparam logic [2:0] OP_VV = 3'b001;
  localparam logic [2:0] OP_VX = 3'b010;
  localparam logic [2:0] OP_VI = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } seq_state_e;

  // Illegal vsew codes report zero elements so the instruction retires empty.
  function automatic int unsigned vlmax(input int unsigned vlen, input logic [2:0] vsew);
    int unsigned r;
    case (vsew)
      3'd0:    r = vlen >> 32'd3;
      3'd1:    r = vlen >> 32'd4;
      3'd2:    r = vlen >> 32'd5;
      3'd3:    r = vlen >> 32'd6;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] sew_mask(input logic [2:0] vsew);
    logic [63:0] m;
    case (vsew)
      3'd0:    m = 64'h0000_0000_0000_00FF;
      3'd1:    m = 64'h0000_0000_0000_FFFF;
      3'd2:    m = 64'h0000_0000_FFFF_FFFF;
      3'd3:    m = 64'hFFFF_FFFF_FFFF_FFFF;
      default: m = 64'h0000_0000_0000_0000;
    endcase
    return m;
  endfunction

  // Sign-extend a 32-bit scalar to 64 bits, then keep only SEW bits so that
  // everything above SEW reads as zero on the lane bus.
  function automatic logic [63:0] sext_sew(input logic [31:0] value, input logic [2:0] vsew);
    logic [63:0] ext;
    ext = {{32{value[31]}}, value};
    return ext & sew_mask(vsew);
  endfunction

  function automatic int unsigned elem_bit_off(input int unsigned idx, input logic [2:0] vsew);
    int unsigned off;
    case (vsew)
      3'd0:    off = idx << 32'd3;
      3'd1:    off = idx << 32'd4;
      3'd2:    off = idx << 32'd5;
      3'd3:    off = idx << 32'd6;
      default: off = 32'd0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/vec_lane_sequencer_if.sv
// vec_lane_sequencer_if -- beat bus between the sequencer and the lane ALUs.
//   lane_valid : per-lane element active this beat       (sequencer -> lanes)
//   lane_a     : vs2 elements, zero-extended from SEW      (sequencer -> lanes)
//   lane_b     : vs1 element / rs1 / imm5 per op_type      (sequencer -> lanes)
//   lane_ready : lanes accept the current beat             (lanes -> sequencer)
//   lane_res   : lane results, low SEW bits meaningful     (lanes -> sequencer)
interface vec_lane_sequencer_if #(
  parameter int LANES = 4,
  parameter int ELEN  = 64
);
  logic [LANES-1:0]      lane_valid;
  logic [LANES*ELEN-1:0] lane_a;
  logic [LANES*ELEN-1:0] lane_b;
  logic                  lane_ready;
  logic [LANES*ELEN-1:0] lane_res;

  modport master (
    output lane_valid, lane_a, lane_b,
    input  lane_ready, lane_res
  );

  modport slave (
    input  lane_valid, lane_a, lane_b,
    output lane_ready, lane_res
  );
endinterface

// File: rtl/vec_elem_select.sv
// vec_elem_select -- combinational element extractor.
//   vec  : VLEN-bit vector register
//   idx  : element index (may point past the register; result is then 0)
//   vsew : element width code, SEW = 8 << vsew
//   elem : element idx, zero-extended from SEW to ELEN
module vec_elem_select
  import vec_seq_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 64,
  parameter int IDXW = 6
) (
  input  logic [VLEN-1:0] vec,
  input  logic [IDXW-1:0] idx,
  input  logic [2:0]      vsew,
  output logic [ELEN-1:0] elem
);

  logic [31:0]     bit_off_s;
  logic [VLEN-1:0] shifted_s;

  // Shift the wanted element down to bit 0 and trim to SEW.
  always_comb begin
    bit_off_s = elem_bit_off(32'(idx), vsew);
    shifted_s = vec >> bit_off_s;
    elem      = ELEN'(shifted_s) & ELEN'(sew_mask(vsew));
  end

endmodule

// File: rtl/vec_lane_sequencer.sv
// vec_lane_sequencer -- sequences one vector instruction across LANES lanes.
// Ports:
//   clk, resetn          : clock, synchronous active-low reset
//   start                : launch (sampled only in IDLE)
//   vsew, op_type, vl    : element width code, one-hot op kind, element count
//   vs1, vs2, vd_old     : source registers and undisturbed destination
//   rs1, imm5            : scalar operands for VX / VI
//   vm, v0               : mask controls (only with VEC_SEQ_MASK_EN)
//   lane                 : beat bus to the lane ALUs (master side)
//   busy, done, vd       : in-progress flag, completion pulse, result register
// Optional build macro VEC_SEQ_MASK_EN adds vm/v0 masking (mask-undisturbed).
module vec_lane_sequencer
  import vec_seq_pkg::*;
#(
  parameter  int VLEN  = 128,
  parameter  int LANES = 4,
  parameter  int ELEN  = 64,
  localparam int VLW   = $clog2(VLEN/8) + 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [2:0]          vsew,
  input  logic [2:0]          op_type,
  input  logic [VLW-1:0]      vl,
  input  logic [VLEN-1:0]     vs1,
  input  logic [VLEN-1:0]     vs2,
  input  logic [VLEN-1:0]     vd_old,
  input  logic [31:0]         rs1,
  input  logic [4:0]          imm5,
`ifdef VEC_SEQ_MASK_EN
  input  logic                vm,
  input  logic [VLEN/8-1:0]   v0,
`endif
  vec_lane_sequencer_if.master lane,
  output logic                busy,
  output logic                done,
  output logic [VLEN-1:0]     vd
);

  // One extra bit so base+LANES past the last element never wraps.
  localparam int IDXW = VLW + 1;

  seq_state_e       state_q, state_d;
  logic [2:0]       vsew_q, vsew_d;
  logic [2:0]       op_q, op_d;
  logic [VLEN-1:0]  vs1_q, vs1_d;
  logic [VLEN-1:0]  vs2_q, vs2_d;
  logic [VLEN-1:0]  vd_q, vd_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [4:0]       imm5_q, imm5_d;
  logic [IDXW-1:0]  vl_eff_q, vl_eff_d;
  logic [IDXW-1:0]  base_q, base_d;
`ifdef VEC_SEQ_MASK_EN
  logic             vm_q, vm_d;
  logic [VLEN/8-1:0] v0_q, v0_d;
`endif

  logic [IDXW-1:0]       vlmax_s;
  logic [IDXW-1:0]       vl_in_s;
  logic [IDXW-1:0]       vl_start_s;
  logic [IDXW-1:0]       elem_idx_s [LANES];
  logic [ELEN-1:0]       elem_a_s   [LANES];
  logic [ELEN-1:0]       elem_b_s   [LANES];
  logic [LANES-1:0]      lane_valid_s;
  logic [LANES*ELEN-1:0] lane_a_s;
  logic [LANES*ELEN-1:0] lane_b_s;
  logic [ELEN-1:0]       scalar_b_s;
  logic [VLEN-1:0]       sew_vmask_s;

  // Effective element count at launch: vl clamped to VLMAX (0 for bad vsew).
  always_comb begin
    vlmax_s = IDXW'(vlmax(VLEN, vsew));
    vl_in_s = IDXW'(vl);
    if (vl_in_s < vlmax_s) begin
      vl_start_s = vl_in_s;
    end else begin
      vl_start_s = vlmax_s;
    end
  end

  // Element index carried by each lane in the current beat.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      elem_idx_s[i] = base_q + IDXW'(i);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_sel
    vec_elem_select #(.VLEN(VLEN), .ELEN(ELEN), .IDXW(IDXW)) u_sel_a (
      .vec  (vs2_q),
      .idx  (elem_idx_s[g]),
      .vsew (vsew_q),
      .elem (elem_a_s[g])
    );
    vec_elem_select #(.VLEN(VLEN), .ELEN(ELEN), .IDXW(IDXW)) u_sel_b (
      .vec  (vs1_q),
      .idx  (elem_idx_s[g]),
      .vsew (vsew_q),
      .elem (elem_b_s[g])
    );
  end

  // Per-lane activity: body element, and (optionally) not masked off.
  always_comb begin
    lane_valid_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((state_q == ST_RUN) && (elem_idx_s[i] < vl_eff_q)) begin
`ifdef VEC_SEQ_MASK_EN
        lane_valid_s[i] = vm_q |
          (((v0_q >> elem_idx_s[i]) & {{(VLEN/8-1){1'b0}}, 1'b1}) != '0);
`else
        lane_valid_s[i] = 1'b1;
`endif
      end else begin
        lane_valid_s[i] = 1'b0;
      end
    end
  end

  // Scalar second operand shared by every lane for VX / VI.
  always_comb begin
    case (op_q)
      OP_VX:   scalar_b_s = ELEN'(sext_sew(rs1_q, vsew_q));
      OP_VI:   scalar_b_s = ELEN'(sext_sew({{27{imm5_q[4]}}, imm5_q}, vsew_q));
      default: scalar_b_s = '0;
    endcase
  end

  // Lane operand buses; inactive lanes are driven to zero.
  always_comb begin
    lane_a_s = '0;
    lane_b_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_valid_s[i]) begin
        lane_a_s[i*ELEN +: ELEN] = elem_a_s[i];
        if (op_q == OP_VV) begin
          lane_b_s[i*ELEN +: ELEN] = elem_b_s[i];
        end else begin
          lane_b_s[i*ELEN +: ELEN] = scalar_b_s;
        end
      end else begin
        lane_a_s[i*ELEN +: ELEN] = '0;
        lane_b_s[i*ELEN +: ELEN] = '0;
      end
    end
  end

  assign lane.lane_valid = lane_valid_s;
  assign lane.lane_a     = lane_a_s;
  assign lane.lane_b     = lane_b_s;

  // Next-state, operand latching and write-back of accepted beats.
  always_comb begin
    state_d  = state_q;
    vsew_d   = vsew_q;
    op_d     = op_q;
    vs1_d    = vs1_q;
    vs2_d    = vs2_q;
    vd_d     = vd_q;
    rs1_d    = rs1_q;
    imm5_d   = imm5_q;
    vl_eff_d = vl_eff_q;
    base_d   = base_q;
`ifdef VEC_SEQ_MASK_EN
    vm_d     = vm_q;
    v0_d     = v0_q;
`endif
    sew_vmask_s = VLEN'(sew_mask(vsew_q));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          vsew_d   = vsew;
          op_d     = op_type;
          vs1_d    = vs1;
          vs2_d    = vs2;
          rs1_d    = rs1;
          imm5_d   = imm5;
          vl_eff_d = vl_start_s;
          vd_d     = vd_old;
          base_d   = '0;
`ifdef VEC_SEQ_MASK_EN
          vm_d     = vm;
          v0_d     = v0;
`endif
          if (vl_start_s == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (lane.lane_ready) begin
          // Merge each active lane's SEW-bit result into its element slot.
          for (int i = 0; i < LANES; i++) begin
            if (lane_valid_s[i]) begin
              vd_d = (vd_d & ~(sew_vmask_s << elem_bit_off(32'(elem_idx_s[i]), vsew_q)))
                   | ((VLEN'(lane.lane_res[i*ELEN +: ELEN]) & sew_vmask_s)
                      << elem_bit_off(32'(elem_idx_s[i]), vsew_q));
            end else begin
              vd_d = vd_d;
            end
          end
          base_d = base_q + IDXW'(LANES);
          if ((base_q + IDXW'(LANES)) >= vl_eff_q) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and operand registers; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      vsew_q   <= 3'd0;
      op_q     <= 3'd0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_q     <= '0;
      rs1_q    <= 32'd0;
      imm5_q   <= 5'd0;
      vl_eff_q <= '0;
      base_q   <= '0;
`ifdef VEC_SEQ_MASK_EN
      vm_q     <= 1'b0;
      v0_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      vsew_q   <= vsew_d;
      op_q     <= op_d;
      vs1_q    <= vs1_d;
      vs2_q    <= vs2_d;
      vd_q     <= vd_d;
      rs1_q    <= rs1_d;
      imm5_q   <= imm5_d;
      vl_eff_q <= vl_eff_d;
      base_q   <= base_d;
`ifdef VEC_SEQ_MASK_EN
      vm_q     <= vm_d;
      v0_q     <= v0_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_FIN);
  assign vd   = vd_q;

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// tb_vec_lane_sequencer -- directed bench for vec_lane_sequencer with
// adder lanes (lane_res = lane_a + lane_b, full 64-bit).
module tb_vec_lane_sequencer;
  import vec_seq_pkg::*;

  localparam int VLEN  = 128;
  localparam int LANES = 4;
  localparam int ELEN  = 64;
  localparam int VLW   = $clog2(VLEN/8) + 1;

  logic              clk;
  logic              resetn;
  logic              start;
  logic [2:0]        vsew;
  logic [2:0]        op_type;
  logic [VLW-1:0]    vl;
  logic [VLEN-1:0]   vs1, vs2, vd_old;
  logic [31:0]       rs1;
  logic [4:0]        imm5;
  logic              ready;
  logic              busy, done;
  logic [VLEN-1:0]   vd;
`ifdef VEC_SEQ_MASK_EN
  logic              vm;
  logic [VLEN/8-1:0] v0;
`endif
  logic [LANES*ELEN-1:0] lane_res_s;

  int total;
  int bad;

  vec_lane_sequencer_if #(.LANES(LANES), .ELEN(ELEN)) lane_bus ();

  vec_lane_sequencer #(.VLEN(VLEN), .LANES(LANES), .ELEN(ELEN)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .vsew    (vsew),
    .op_type (op_type),
    .vl      (vl),
    .vs1     (vs1),
    .vs2     (vs2),
    .vd_old  (vd_old),
    .rs1     (rs1),
    .imm5    (imm5),
`ifdef VEC_SEQ_MASK_EN
    .vm      (vm),
    .v0      (v0),
`endif
    .lane    (lane_bus),
    .busy    (busy),
    .done    (done),
    .vd      (vd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder lanes.
  always_comb begin
    lane_res_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_res_s[i*ELEN +: ELEN] = lane_bus.lane_a[i*ELEN +: ELEN] + lane_bus.lane_b[i*ELEN +: ELEN];
    end
  end
  assign lane_bus.lane_res   = lane_res_s;
  assign lane_bus.lane_ready = ready;

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic launch(input logic [2:0] sew, input logic [2:0] op, input logic [VLW-1:0] len,
                        input logic [VLEN-1:0] a2, input logic [VLEN-1:0] a1,
                        input logic [VLEN-1:0] old, input logic [31:0] r1, input logic [4:0] im);
    vsew = sew; op_type = op; vl = len; vs2 = a2; vs1 = a1; vd_old = old; rs1 = r1; imm5 = im;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observe from cycle 1 until done (bounded); ends one cycle after done.
  task automatic run_collect(output int done_cyc, output int beats, output logic [LANES-1:0] first_valid);
    done_cyc = -1; beats = 0; first_valid = '0;
    for (int c = 1; c <= 40; c++) begin
      if (lane_bus.lane_valid != '0) begin
        if (beats == 0) first_valid = lane_bus.lane_valid;
        if (ready) beats++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    total++; if (vd !== '0) begin bad++; $display("FAIL reset_vd got=%h want=0", vd); end
    total++; if (lane_bus.lane_valid !== '0) begin bad++; $display("FAIL reset_lane_valid got=%b want=0", lane_bus.lane_valid); end
    total++; if (lane_bus.lane_a !== '0) begin bad++; $display("FAIL reset_lane_a got=%h want=0", lane_bus.lane_a); end
    total++; if (lane_bus.lane_b !== '0) begin bad++; $display("FAIL reset_lane_b got=%h want=0", lane_bus.lane_b); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vv_sew8();
    int dc, nb; logic [LANES-1:0] fv;
    launch(3'd0, OP_VV, 5'd16, {16{8'h01}}, {16{8'h01}}, {16{8'hAA}}, 32'd0, 5'd0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL vv_busy got=%0b want=1", busy); end
    total++; if (lane_bus.lane_a[63:0] !== 64'h1) begin bad++; $display("FAIL vv_lane_a0 got=%h want=1", lane_bus.lane_a[63:0]); end
    run_collect(dc, nb, fv);
    total++; if (fv !== 4'b1111) begin bad++; $display("FAIL vv_valid got=%b want=1111", fv); end
    total++; if (nb !== 4) begin bad++; $display("FAIL vv_beats got=%0d want=4", nb); end
    total++; if (dc !== 5) begin bad++; $display("FAIL vv_done_cycle got=%0d want=5", dc); end
    total++; if (vd !== {16{8'h02}}) begin bad++; $display("FAIL vv_vd got=%h want=%h", vd, {16{8'h02}}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL vv_idle_busy got=%0b want=0", busy); end
  endtask

  task automatic test_sew32_tail();
    int dc, nb; logic [LANES-1:0] fv;
    launch(3'd2, OP_VV, 5'd3, {32'h4, 32'h3, 32'h2, 32'h1}, {32'h40, 32'h30, 32'h20, 32'h10},
           {128{1'b1}}, 32'd0, 5'd0);
    total++; if (lane_bus.lane_a[127:64] !== 64'h2) begin bad++; $display("FAIL tail_lane_a1 got=%h want=2", lane_bus.lane_a[127:64]); end
    run_collect(dc, nb, fv);
    total++; if (fv !== 4'b0111) begin bad++; $display("FAIL tail_valid got=%b want=0111", fv); end
    total++; if (nb !== 1) begin bad++; $display("FAIL tail_beats got=%0d want=1", nb); end
    total++; if (dc !== 2) begin bad++; $display("FAIL tail_done_cycle got=%0d want=2", dc); end
    total++; if (vd !== {32'hFFFF_FFFF, 32'h33, 32'h22, 32'h11}) begin bad++; $display("FAIL tail_vd got=%h want=%h", vd, {32'hFFFF_FFFF, 32'h33, 32'h22, 32'h11}); end
  endtask

  task automatic test_vl_zero();
    int dc, nb; logic [LANES-1:0] fv;
    logic [VLEN-1:0] old1, old2;
    old1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    old2 = 128'h5A5A_0000_1111_2222_3333_4444_5555_6666;
    launch(3'd0, OP_VV, 5'd0, {16{8'h01}}, {16{8'h01}}, old1, 32'd0, 5'd0);
    run_collect(dc, nb, fv);
    total++; if ((fv !== '0) || (nb !== 0)) begin bad++; $display("FAIL vl0_valid got=%b/%0d want=0/0", fv, nb); end
    total++; if (dc !== 1) begin bad++; $display("FAIL vl0_done_cycle got=%0d want=1", dc); end
    total++; if (vd !== old1) begin bad++; $display("FAIL vl0_vd got=%h want=%h", vd, old1); end
    // Illegal vsew behaves like an empty instruction.
    launch(3'd4, OP_VV, 5'd5, {16{8'h01}}, {16{8'h01}}, old2, 32'd0, 5'd0);
    run_collect(dc, nb, fv);
    total++; if (nb !== 0) begin bad++; $display("FAIL badsew_beats got=%0d want=0", nb); end
    total++; if (dc !== 1) begin bad++; $display("FAIL badsew_done_cycle got=%0d want=1", dc); end
    total++; if (vd !== old2) begin bad++; $display("FAIL badsew_vd got=%h want=%h", vd, old2); end
  endtask

  task automatic test_clamp();
    int dc, nb; logic [LANES-1:0] fv;
    launch(3'd1, OP_VV, 5'd20, 128'h0008_0007_0006_0005_0004_0003_0002_0001, {8{16'h1000}},
           '0, 32'd0, 5'd0);
    run_collect(dc, nb, fv);
    total++; if (nb !== 2) begin bad++; $display("FAIL clamp_beats got=%0d want=2", nb); end
    total++; if (dc !== 3) begin bad++; $display("FAIL clamp_done_cycle got=%0d want=3", dc); end
    total++; if (vd !== 128'h1008_1007_1006_1005_1004_1003_1002_1001) begin bad++; $display("FAIL clamp_vd got=%h want=%h", vd, 128'h1008_1007_1006_1005_1004_1003_1002_1001); end
  endtask

  task automatic test_stall();
    logic [LANES*ELEN-1:0] snap_a, snap_b;
    launch(3'd0, OP_VV, 5'd8, 128'h0807_0605_0403_0201, {16{8'h10}}, {16{8'hEE}}, 32'd0, 5'd0);
    @(negedge clk);                      // cycle 2
    ready = 1'b0;
    snap_a = lane_bus.lane_a;
    snap_b = lane_bus.lane_b;
    total++; if (lane_bus.lane_a[63:0] !== 64'h05) begin bad++; $display("FAIL stall_lane_a0 got=%h want=05", lane_bus.lane_a[63:0]); end
    @(negedge clk);                      // cycle 3
    total++; if (lane_bus.lane_a !== snap_a) begin bad++; $display("FAIL stall_a_stable got=%h want=%h", lane_bus.lane_a, snap_a); end
    total++; if (lane_bus.lane_b !== snap_b) begin bad++; $display("FAIL stall_b_stable got=%h want=%h", lane_bus.lane_b, snap_b); end
    total++; if (lane_bus.lane_b[63:0] !== 64'h10) begin bad++; $display("FAIL stall_lane_b0 got=%h want=10", lane_bus.lane_b[63:0]); end
    @(negedge clk);                      // cycle 4
    ready = 1'b1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL stall_early_done got=%0b want=0", done); end
    @(negedge clk);                      // cycle 5
    total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done_c5 got=%0b want=1", done); end
    @(negedge clk);
    total++; if (vd !== {{8{8'hEE}}, 64'h1817_1615_1413_1211}) begin bad++; $display("FAIL stall_vd got=%h want=%h", vd, {{8{8'hEE}}, 64'h1817_1615_1413_1211}); end
  endtask

  task automatic test_vx_vi();
    int dc, nb; logic [LANES-1:0] fv;
    launch(3'd0, OP_VX, 5'd4, 128'h0403_0201, '0, '0, 32'hFFFF_FF80, 5'd0);
    total++; if (lane_bus.lane_b[63:0] !== 64'h80) begin bad++; $display("FAIL vx_lane_b0 got=%h want=80", lane_bus.lane_b[63:0]); end
    total++; if (lane_bus.lane_b[127:64] !== 64'h80) begin bad++; $display("FAIL vx_lane_b1 got=%h want=80", lane_bus.lane_b[127:64]); end
    run_collect(dc, nb, fv);
    total++; if (vd !== 128'h8483_8281) begin bad++; $display("FAIL vx_vd got=%h want=84838281", vd); end
    launch(3'd1, OP_VI, 5'd2, 128'h0010_0005, '0, {8{16'hAAAA}}, 32'd0, 5'b11110);
    total++; if (lane_bus.lane_b[63:0] !== 64'hFFFE) begin bad++; $display("FAIL vi_lane_b0 got=%h want=fffe", lane_bus.lane_b[63:0]); end
    run_collect(dc, nb, fv);
    total++; if (dc !== 2) begin bad++; $display("FAIL vi_done_cycle got=%0d want=2", dc); end
    total++; if (vd !== 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_000E_0003) begin bad++; $display("FAIL vi_vd got=%h want=%h", vd, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_000E_0003); end
  endtask

  task automatic test_reset_midrun();
    launch(3'd0, OP_VV, 5'd16, {16{8'h01}}, {16{8'h01}}, {16{8'hAA}}, 32'd0, 5'd0);
    @(negedge clk);                      // cycle 2, beat 2
    resetn = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b want=0", busy); end
    total++; if (vd !== '0) begin bad++; $display("FAIL midrst_vd got=%h want=0", vd); end
    total++; if (lane_bus.lane_valid !== '0) begin bad++; $display("FAIL midrst_valid got=%b want=0", lane_bus.lane_valid); end
    resetn = 1'b1;
    @(negedge clk);
    total++; if ((busy !== 1'b0) || (done !== 1'b0)) begin bad++; $display("FAIL midrst_after got=%0b%0b want=00", busy, done); end
  endtask

  task automatic test_back_to_back();
    int dcount, dcyc;
    vsew = 3'd0; op_type = OP_VV; vl = 5'd16; vs1 = {16{8'h01}}; vs2 = {16{8'h01}};
    vd_old = {16{8'hAA}}; rs1 = 32'd0; imm5 = 5'd0;
    start = 1'b1;
    @(negedge clk);                      // cycle 1; start stays high while busy
    vd_old = '0; vl = 5'd1; vs1 = {16{8'h07}};
    dcount = 0; dcyc = 0;
    for (int c = 1; c <= 5; c++) begin
      if (done) begin dcount++; dcyc = c; end
      @(negedge clk);
    end
    start = 1'b0;                        // cycle 6
    total++; if (dcount !== 1) begin bad++; $display("FAIL b2b_done_count got=%0d want=1", dcount); end
    total++; if (dcyc !== 5) begin bad++; $display("FAIL b2b_done_cycle got=%0d want=5", dcyc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_fin_start got=%0b want=0", busy); end
    total++; if (vd !== {16{8'h02}}) begin bad++; $display("FAIL b2b_vd got=%h want=%h", vd, {16{8'h02}}); end
    @(negedge clk);
  endtask

`ifdef VEC_SEQ_MASK_EN
  task automatic test_mask();
    int dc, nb; logic [LANES-1:0] fv;
    vm = 1'b0; v0 = 16'h5555;
    launch(3'd0, OP_VV, 5'd16, {16{8'h01}}, {16{8'h01}}, {16{8'hAA}}, 32'd0, 5'd0);
    run_collect(dc, nb, fv);
    total++; if (fv !== 4'b0101) begin bad++; $display("FAIL mask_valid got=%b want=0101", fv); end
    total++; if (vd !== {8{16'hAA02}}) begin bad++; $display("FAIL mask_vd got=%h want=%h", vd, {8{16'hAA02}}); end
    vm = 1'b1;
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    resetn = 1'b0; start = 1'b0; ready = 1'b1;
    vsew = 3'd0; op_type = OP_VV; vl = '0; vs1 = '0; vs2 = '0; vd_old = '0;
    rs1 = 32'd0; imm5 = 5'd0;
`ifdef VEC_SEQ_MASK_EN
    vm = 1'b1; v0 = '0;
`endif
    test_reset();
    test_vv_sew8();
    test_sew32_tail();
    test_vl_zero();
    test_clamp();
    test_stall();
    test_vx_vi();
    test_reset_midrun();
    test_back_to_back();
`ifdef VEC_SEQ_MASK_EN
    test_mask();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
